// File: rtl/uart_tx_serializer.sv
// UART transmitter for the debug unit: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Owns its baud divider; o_tx_done is a registered ready level for the upstream send FSM.
module uart_tx_serializer #(
    parameter int UART_BITS    = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tx_start,
    input  logic [UART_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(UART_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(UART_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic              PARITY_EN  = (PARITY_MODE != 0);
    localparam logic              PARITY_ODD = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_r,  state_n_s;
    logic [BAUD_W-1:0]    baud_cnt_r, baud_n_s;
    logic [BIT_W-1:0]     bit_cnt_r,  bit_n_s;
    logic [UART_BITS-1:0] shift_r,    shift_n_s;
    logic                 parity_r,   parity_n_s;
    logic                 tx_r,       tx_n_s;
    logic                 done_r,     done_n_s;
    logic                 bit_end_s;

    // Parity is taken from the byte as latched, before any shifting.
    function automatic logic calc_parity(input logic [UART_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // Next-state, counters and next output values; outputs are registered from these.
    always_comb begin
        state_n_s  = state_r;
        baud_n_s   = baud_cnt_r;
        bit_n_s    = bit_cnt_r;
        shift_n_s  = shift_r;
        parity_n_s = parity_r;
        tx_n_s     = tx_r;
        done_n_s   = done_r;
        bit_end_s  = (baud_cnt_r == BAUD_LAST);

        if (state_r == ST_IDLE) begin
            baud_n_s = '0;
        end else if (bit_end_s) begin
            baud_n_s = '0;
        end else begin
            baud_n_s = baud_cnt_r + BAUD_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                if (i_tx_start) begin
                    state_n_s  = ST_START;
                    shift_n_s  = i_tx_data;
                    parity_n_s = calc_parity(i_tx_data, PARITY_ODD);
                    bit_n_s    = '0;
                    tx_n_s     = 1'b0;
                    done_n_s   = 1'b0;
                end else begin
                    tx_n_s   = 1'b1;
                    done_n_s = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_n_s = ST_DATA;
                    bit_n_s   = '0;
                    tx_n_s    = shift_r[0];
                end else begin
                    state_n_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_n_s = shift_r >> 1;
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_n_s = '0;
                        if (PARITY_EN) begin
                            state_n_s = ST_PARITY;
                            tx_n_s    = parity_r;
                        end else begin
                            state_n_s = ST_STOP;
                            tx_n_s    = 1'b1;
                        end
                    end else begin
                        bit_n_s = bit_cnt_r + BIT_ONE;
                        tx_n_s  = shift_n_s[0];
                    end
                end else begin
                    state_n_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_n_s = ST_STOP;
                    bit_n_s   = '0;
                    tx_n_s    = 1'b1;
                end else begin
                    state_n_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (bit_cnt_r == STOP_LAST) begin
                        state_n_s = ST_IDLE;
                        bit_n_s   = '0;
                        done_n_s  = 1'b1;
                        tx_n_s    = 1'b1;
                    end else begin
                        bit_n_s = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    state_n_s = ST_STOP;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                baud_n_s  = '0;
                bit_n_s   = '0;
                tx_n_s    = 1'b1;
                done_n_s  = 1'b1;
            end
        endcase
    end

    // State, counters, data and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            done_r     <= 1'b1;
        end else begin
            state_r    <= state_n_s;
            baud_cnt_r <= baud_n_s;
            bit_cnt_r  <= bit_n_s;
            shift_r    <= shift_n_s;
            parity_r   <= parity_n_s;
            tx_r       <= tx_n_s;
            done_r     <= done_n_s;
        end
    end

    assign o_tx      = tx_r;
    assign o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances (no parity, even, odd, two stop bits)
// at 4 clocks per bit, checked cycle by cycle against hand-written frame bit strings.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       start0, start1, start2, start3;
    logic       tx0, tx1, tx2, tx3;
    logic       done0, done1, done2, done3;
    int         checks;
    int         errors;

    uart_tx_serializer #(.UART_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u_none (
        .clk(clk), .rst(rst), .i_tx_start(start0), .i_tx_data(data), .o_tx(tx0), .o_tx_done(done0));
    uart_tx_serializer #(.UART_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .i_tx_start(start1), .i_tx_data(data), .o_tx(tx1), .o_tx_done(done1));
    uart_tx_serializer #(.UART_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .i_tx_start(start2), .i_tx_data(data), .o_tx(tx2), .o_tx_done(done2));
    uart_tx_serializer #(.UART_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .i_tx_start(start3), .i_tx_data(data), .o_tx(tx3), .o_tx_done(done3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_tx(input int inst);
        case (inst)
            0: return tx0;
            1: return tx1;
            2: return tx2;
            default: return tx3;
        endcase
    endfunction

    function automatic logic get_done(input int inst);
        case (inst)
            0: return done0;
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    task automatic set_start(input int inst, input logic val);
        case (inst)
            0: start0 = val;
            1: start1 = val;
            2: start2 = val;
            default: start3 = val;
        endcase
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Called #1 after an edge; pattern holds frame bits, first-sent bit leftmost.
    task automatic run_frame(input string name, input int inst, input logic [7:0] d,
                             input logic [15:0] pattern, input int nbits, input bit inject);
        logic exp_bit;
        data = d;
        set_start(inst, 1'b1);
        @(posedge clk);
        #1;
        set_start(inst, 1'b0);
        check({name, " done_fall"}, get_done(inst), 1'b0);
        for (int c = 0; c < nbits * 4; c++) begin
            exp_bit = pattern[nbits - 1 - c / 4];
            check($sformatf("%s c%0d tx", name, c), get_tx(inst), exp_bit);
            check($sformatf("%s c%0d done", name, c), get_done(inst), 1'b0);
            if (inject && (c == 5 || c == 15 || c == 30)) begin
                data = 8'hFF;
                set_start(inst, 1'b1);
            end else begin
                set_start(inst, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        set_start(inst, 1'b0);
        check({name, " done_rise"}, get_done(inst), 1'b1);
        check({name, " idle_tx"}, get_tx(inst), 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        data   = 8'h00;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset tx0", tx0, 1'b1);
        check("reset done0", done0, 1'b1);
        check("reset tx3", tx3, 1'b1);
        check("reset done3", done3, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame("a5_none", 0, 8'hA5, 16'b0000_0001_0100_1011, 10, 1'b0);
        @(posedge clk);
        #1;
        run_frame("07_even", 1, 8'h07, 16'b0000_0011_1000_0011, 11, 1'b0);
        @(posedge clk);
        #1;
        run_frame("07_odd", 2, 8'h07, 16'b0000_0011_1000_0001, 11, 1'b0);
        @(posedge clk);
        #1;
        run_frame("00_stop2", 3, 8'h00, 16'b0000_0000_0000_0011, 11, 1'b0);
        @(posedge clk);
        #1;
        run_frame("3c_ignore", 0, 8'h3C, 16'b0000_0000_0111_1001, 10, 1'b1);
        @(posedge clk);
        #1;
        check("no_queued_start done", done0, 1'b1);
        check("no_queued_start tx", tx0, 1'b1);

        run_frame("81_b2b", 0, 8'h81, 16'b0000_0001_0000_0011, 10, 1'b0);
        run_frame("42_b2b", 0, 8'h42, 16'b0000_0000_1000_0101, 10, 1'b0);
        @(posedge clk);
        #1;

        data   = 8'hA5;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("pre_reset tx", tx0, 1'b0);
        check("pre_reset done", done0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset tx", tx0, 1'b1);
        check("async_reset done", done0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset tx", tx0, 1'b1);
        check("post_reset done", done0, 1'b1);
        run_frame("55_after_rst", 0, 8'h55, 16'b0000_0001_0101_0101, 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
